// File: rtl/mem_port_ctrl.sv
// Memory-side port controller: serialises fetch/load/store requests onto one readM/writeM port.
// Optional MEM_PORT_TIMEOUT_EN adds a wait counter that aborts a stalled access with a mem_err pulse.
module mem_port_ctrl #(
   parameter int WORD_SIZE = 16
`ifdef MEM_PORT_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 if_req,
   input  logic [WORD_SIZE-1:0] if_addr,
   output logic                 if_valid,
   output logic [WORD_SIZE-1:0] if_inst,
   input  logic                 d_rd_req,
   input  logic                 d_wr_req,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_done,
   output logic                 busy,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
`ifdef MEM_PORT_TIMEOUT_EN
   output logic                 mem_err,
`endif
   input  logic                 inputReady,
   input  logic                 ackOutput
);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, RELEASE} state_t;

   state_t               state_q, state_d;
   logic                 readm_q, readm_d;
   logic                 writem_q, writem_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [WORD_SIZE-1:0] if_inst_q, if_inst_d;
   logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
   logic                 if_valid_q, if_valid_d;
   logic                 d_done_q, d_done_d;
   logic                 busy_q, busy_d;

`ifdef MEM_PORT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             timeout;

   // Strobe stays up for exactly TIMEOUT_CYCLES cycles before the abort edge.
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign mem_err = mem_err_q;
`endif

   always_comb begin
      state_d    = state_q;
      readm_d    = readm_q;
      writem_d   = writem_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_inst_d  = if_inst_q;
      d_rdata_d  = d_rdata_q;
      if_valid_d = 1'b0;
      d_done_d   = 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
      cnt_d      = cnt_q;
      mem_err_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef MEM_PORT_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (d_wr_req) begin
               state_d  = STORE;
               writem_d = 1'b1;
               addr_d   = d_addr;
               wdata_d  = d_wdata;
            end else if (d_rd_req) begin
               state_d = LOAD;
               readm_d = 1'b1;
               addr_d  = d_addr;
            end else if (if_req) begin
               state_d = FETCH;
               readm_d = 1'b1;
               addr_d  = if_addr;
            end
         end
         FETCH, LOAD: begin
            if (inputReady) begin
               readm_d = 1'b0;
               state_d = RELEASE;
               if (state_q == FETCH) begin
                  if_inst_d  = data;
                  if_valid_d = 1'b1;
               end else begin
                  d_rdata_d = data;
                  d_done_d  = 1'b1;
               end
            end
`ifdef MEM_PORT_TIMEOUT_EN
            else if (timeout) begin
               readm_d   = 1'b0;
               mem_err_d = 1'b1;
               state_d   = RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         STORE: begin
            if (ackOutput) begin
               writem_d = 1'b0;
               d_done_d = 1'b1;
               state_d  = RELEASE;
            end
`ifdef MEM_PORT_TIMEOUT_EN
            else if (timeout) begin
               writem_d  = 1'b0;
               mem_err_d = 1'b1;
               state_d   = RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RELEASE: begin
            // Hold off the next strobe until the memory has dropped both handshakes.
            if (!inputReady && !ackOutput) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q    <= IDLE;
         readm_q    <= 1'b0;
         writem_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_inst_q  <= '0;
         d_rdata_q  <= '0;
         if_valid_q <= 1'b0;
         d_done_q   <= 1'b0;
         busy_q     <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
         cnt_q      <= '0;
         mem_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         readm_q    <= readm_d;
         writem_q   <= writem_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_inst_q  <= if_inst_d;
         d_rdata_q  <= d_rdata_d;
         if_valid_q <= if_valid_d;
         d_done_q   <= d_done_d;
         busy_q     <= busy_d;
`ifdef MEM_PORT_TIMEOUT_EN
         cnt_q      <= cnt_d;
         mem_err_q  <= mem_err_d;
`endif
      end
   end

   // Bus is driven only from the state register, so reset releases it at once.
   assign data     = (state_q == STORE) ? wdata_q : {WORD_SIZE{1'bz}};
   assign readM    = readm_q;
   assign writeM   = writem_q;
   assign address  = addr_q;
   assign if_inst  = if_inst_q;
   assign d_rdata  = d_rdata_q;
   assign if_valid = if_valid_q;
   assign d_done   = d_done_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: transaction-level reference model, random memory latencies and
// requesters, plus directed fetch/store/priority/release-hold/reset cases with literal values.
module tb_mem_port_ctrl;
   localparam int W    = 16;
   localparam int K_IF = 0;
   localparam int K_LD = 1;
   localparam int K_ST = 2;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         if_req = 1'b0, d_rd_req = 1'b0, d_wr_req = 1'b0;
   logic [W-1:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic         if_valid, d_done, busy, readM, writeM;
   logic [W-1:0] if_inst, d_rdata, address;
   wire  [W-1:0] data;
   logic         inputReady = 1'b0, ackOutput = 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
   logic         mem_err;
`endif

   logic [W-1:0] mem_dq = '0;
   logic         drv_store = 1'b0;
   logic [W-1:0] mem [256];

   assign data = drv_store ? {W{1'bz}} : mem_dq;

   always #5 clk = ~clk;

   mem_port_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
      .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .busy(busy),
      .readM(readM), .writeM(writeM), .address(address), .data(data),
`ifdef MEM_PORT_TIMEOUT_EN
      .mem_err(mem_err),
`endif
      .inputReady(inputReady), .ackOutput(ackOutput)
   );

   // Reference model: one outstanding access; phases are "strobing" and "waiting for release".
   logic         m_busy = 1'b0, m_wait = 1'b0, m_ifv = 1'b0, m_done = 1'b0;
   int           m_kind = K_IF;
   logic [W-1:0] m_addr = '0, m_wd = '0, m_inst = '0, m_rdata = '0;

   always @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         m_busy = 1'b0; m_wait = 1'b0; m_ifv = 1'b0; m_done = 1'b0; m_kind = K_IF;
         m_addr = '0; m_wd = '0; m_inst = '0; m_rdata = '0;
         drv_store <= 1'b0;
      end else begin
         m_ifv  = 1'b0;
         m_done = 1'b0;
         if (!m_busy) begin
            if (d_wr_req || d_rd_req || if_req) begin
               m_busy = 1'b1;
               m_wait = 1'b1;
               m_kind = d_wr_req ? K_ST : (d_rd_req ? K_LD : K_IF);
               m_addr = (m_kind == K_IF) ? if_addr : d_addr;
               if (m_kind == K_ST) m_wd = d_wdata;
            end
         end else if (m_wait) begin
            if ((m_kind == K_ST) ? ackOutput : inputReady) begin
               m_wait = 1'b0;
               if (m_kind == K_IF) begin m_inst = mem_dq; m_ifv = 1'b1; end
               else if (m_kind == K_LD) begin m_rdata = mem_dq; m_done = 1'b1; end
               else m_done = 1'b1;
            end
         end else if (!inputReady && !ackOutput) begin
            m_busy = 1'b0;
         end
         drv_store <= m_busy && m_wait && (m_kind == K_ST);
      end
   end

   int nvec = 0, nerr = 0;
   int force_wait = -1, force_hold = -1;
   int r_phase = 0, r_wait = 0, r_hold = 0;
   bit r_wr = 0, spur_ir = 0, spur_ack = 0, drop_if = 0, drop_d = 0;

   task automatic chk_b(input string nm, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk_b("readM", readM, m_busy && m_wait && (m_kind != K_ST));
      chk_b("writeM", writeM, m_busy && m_wait && (m_kind == K_ST));
      chk_b("busy", busy, m_busy);
      chk_b("if_valid", if_valid, m_ifv);
      chk_b("d_done", d_done, m_done);
      chk_w("address", address, m_addr);
      chk_w("if_inst", if_inst, m_inst);
      chk_w("d_rdata", d_rdata, m_rdata);
      chk_w("data", data, drv_store ? m_wd : mem_dq);
`ifdef MEM_PORT_TIMEOUT_EN
      chk_b("mem_err", mem_err, 1'b0);
`endif
   endtask

   // Memory model: random wait before ack, random hold after strobe drops, spurious wrong-type acks.
   task automatic respond();
      if (spur_ir) begin inputReady = 1'b0; spur_ir = 0; end
      if (spur_ack) begin ackOutput = 1'b0; spur_ack = 0; end
      mem_dq = W'($urandom);
      if (r_phase == 0 && (readM || writeM)) begin
         r_phase = 1;
         r_wr    = writeM;
         r_wait  = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
      end
      if (r_phase == 1) begin
         if (r_wait == 0) begin
            if (r_wr) begin ackOutput = 1'b1; mem[address[7:0]] = data; end
            else begin inputReady = 1'b1; mem_dq = mem[address[7:0]]; end
            r_phase = 2;
            r_hold  = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 2));
         end else begin
            r_wait--;
            if ($urandom_range(0, 3) == 0) begin
               if (r_wr) begin inputReady = 1'b1; spur_ir = 1; end
               else begin ackOutput = 1'b1; spur_ack = 1; end
            end
         end
      end else if (r_phase == 2 && !readM && !writeM) begin
         if (r_hold == 0) begin inputReady = 1'b0; ackOutput = 1'b0; r_phase = 0; end
         else r_hold--;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare();
      respond();
      drop_if = 0;
      drop_d  = 0;
      if (m_ifv) begin if_req = 1'b0; drop_if = 1; end
      if (m_done) begin
         if (m_kind == K_LD) d_rd_req = 1'b0; else d_wr_req = 1'b0;
         drop_d = 1;
      end
   endtask

   task automatic wait_pulse(input string nm, input bit want_if);
      bit got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         cycle();
         got = want_if ? m_ifv : m_done;
      end
      nvec++;
      if (!got) begin
         nerr++;
         $display("FAIL %s: completion pulse got 0 want 1 within 60 cycles", nm);
      end
   endtask

   task automatic resp_reset();
      r_phase = 0; spur_ir = 0; spur_ack = 0;
      inputReady = 1'b0; ackOutput = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd, ni, first_kind;
      for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
      mem[8'h00] = 16'h6A05;
      mem[8'h10] = 16'h1234;
      mem[8'h20] = 16'h0F0F;
      mem[8'h01] = 16'hA5C3;
      mem_dq = W'($urandom);
      #1 reset_n = 1'b1;
      repeat (3) cycle();
      chk_b("rst readM", readM, 1'b0);
      chk_b("rst busy", busy, 1'b0);
      chk_w("rst address", address, 16'h0000);
      chk_w("rst if_inst", if_inst, 16'h0000);
      reset_n = 1'b0;
      repeat (2) cycle();

      // Fetch with a 2-cycle memory.
      force_wait = 2;
      if_req = 1'b1; if_addr = 16'h0000;
      cycle();
      chk_b("fetch readM up", readM, 1'b1);
      chk_w("fetch address", address, 16'h0000);
      wait_pulse("fetch", 1);
      chk_b("fetch if_valid", if_valid, 1'b1);
      chk_w("fetch if_inst", if_inst, 16'h6A05);
      chk_b("fetch readM down", readM, 1'b0);
      repeat (3) cycle();

      // Store drives the bus until ack.
      d_wr_req = 1'b1; d_addr = 16'h00C0; d_wdata = 16'hBEEF;
      cycle();
      chk_b("store writeM", writeM, 1'b1);
      chk_w("store data", data, 16'hBEEF);
      wait_pulse("store", 0);
      chk_b("store writeM down", writeM, 1'b0);
      chk_w("store mem word", mem[8'hC0], 16'hBEEF);
      force_wait = -1;
      repeat (3) cycle();

      // Load beats a simultaneous fetch.
      if_req = 1'b1; if_addr = 16'h0020; d_rd_req = 1'b1; d_addr = 16'h0010;
      nd = 0; ni = 0; first_kind = -1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (d_done) begin nd++; if (first_kind < 0) first_kind = K_LD; end
         if (if_valid) begin ni++; if (first_kind < 0) first_kind = K_IF; end
      end
      chk_w("prio d_done count", W'(nd), 16'd1);
      chk_w("prio if_valid count", W'(ni), 16'd1);
      chk_w("prio order", W'(first_kind), W'(K_LD));
      chk_w("prio d_rdata", d_rdata, 16'h1234);
      chk_w("prio if_inst", if_inst, 16'h0F0F);

      // inputReady held 3 edges past capture: no new strobe meanwhile.
      force_wait = 0; force_hold = 3;
      if_req = 1'b1; if_addr = 16'h0000;
      wait_pulse("hold fetch", 1);
      force_hold = -1;
      d_rd_req = 1'b1; d_addr = 16'h0010;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk_b("hold busy", busy, 1'b1);
         chk_b("hold readM", readM, 1'b0);
      end
      wait_pulse("hold load", 0);
      chk_w("hold d_rdata", d_rdata, 16'h1234);
      force_wait = -1;
      repeat (3) cycle();

      // Reset in the middle of a load.
      force_wait = 20;
      d_rd_req = 1'b1; d_addr = 16'h0010;
      repeat (3) cycle();
      chk_b("midload readM", readM, 1'b1);
      #2 reset_n = 1'b1;
      #1;
      chk_b("rst readM drop", readM, 1'b0);
      chk_b("rst busy drop", busy, 1'b0);
      chk_w("rst data released", data, mem_dq);
      d_rd_req = 1'b0;
      resp_reset();
      force_wait = -1;
      repeat (2) begin
         cycle();
         chk_b("rst no d_done", d_done, 1'b0);
      end
      reset_n = 1'b0;
      cycle();
      if_req = 1'b1; if_addr = 16'h0001;
      wait_pulse("post-reset fetch", 1);
      chk_w("post-reset if_inst", if_inst, 16'hA5C3);
      repeat (3) cycle();

      // Random requesters against random memory timing.
      for (int it = 0; it < 600; it++) begin
         cycle();
         if (!if_req && !drop_if && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = W'($urandom);
         end else if ($urandom_range(0, 3) == 0) begin
            if_addr = W'($urandom);
         end
         if (!d_rd_req && !d_wr_req && !drop_d && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 1) d_wr_req = 1'b1; else d_rd_req = 1'b1;
            d_addr = W'($urandom); d_wdata = W'($urandom);
         end else if ($urandom_range(0, 3) == 0) begin
            d_addr = W'($urandom); d_wdata = W'($urandom);
         end
      end
      repeat (60) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
